// File: rtl/hog_pkg.sv
// Shared constants and FSM encoding for the HOG feature-buffer sequencer.
package hog_pkg;

  localparam int HOG_BLOCK_LEN  = 36;
  localparam int HOG_NUM_BLOCKS = 105;
  localparam int HOG_FEAT_LEN   = HOG_BLOCK_LEN * HOG_NUM_BLOCKS;
  localparam int HOG_ADDR_W     = 12;

  localparam logic [2:0] HOG_ST_IDLE = 3'd0;
  localparam logic [2:0] HOG_ST_FILL = 3'd1;
  localparam logic [2:0] HOG_ST_GAP  = 3'd2;
  localparam logic [2:0] HOG_ST_READ = 3'd3;
  localparam logic [2:0] HOG_ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = HOG_ST_IDLE,
    ST_FILL = HOG_ST_FILL,
    ST_GAP  = HOG_ST_GAP,
    ST_READ = HOG_ST_READ,
    ST_DONE = HOG_ST_DONE
  } hog_state_e;

endpackage

// File: rtl/hog_rd_stream.sv
// Feature read-out streamer: walks the buffer address space over a
// valid/ready handshake, holding the address while the consumer stalls.
module hog_rd_stream
  import hog_pkg::*;
#(
  parameter int FEAT_LEN = HOG_FEAT_LEN,
  parameter int ADDR_W   = HOG_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              ready_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o,
  output logic              last_o,
  output logic              fire_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FEAT_LEN - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;

  assign addr_o  = addr_q;
  assign valid_o = valid_q;
  assign last_o  = valid_q && (addr_q == LAST_ADDR);
  assign fire_o  = valid_q && ready_i;

  // Valid rises one cycle after enable and drops after the final handshake;
  // the address parks at zero whenever the stream is not enabled.
  always_comb begin
    addr_d  = addr_q;
    valid_d = en_i && !(fire_o && last_o);
    if (!en_i) begin
      addr_d = '0;
    end else if (fire_o) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Address counter and valid flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/hog_buffer_sequencer.sv
// Frame controller for the HOG feature buffer: accepts normalised blocks,
// strobes them into the buffer, then streams all features to the SVM MAC.
module hog_buffer_sequencer
  import hog_pkg::*;
#(
  parameter int BLOCK_LEN  = HOG_BLOCK_LEN,
  parameter int NUM_BLOCKS = HOG_NUM_BLOCKS,
  parameter int ADDR_W     = HOG_ADDR_W
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic              iBlkValid,
  output logic              oBlkReady,
  output logic              oWR,
  output logic [ADDR_W-1:0] oWrBase,
  output logic [ADDR_W-1:0] oRdAddr,
  output logic              oRdValid,
  input  logic              iRdReady,
  output logic              oLast,
  output logic              oBusy,
  output logic              oDONE
);

  localparam int               FEAT_LEN = BLOCK_LEN * NUM_BLOCKS;
  localparam int               CNT_W    = $clog2(NUM_BLOCKS + 1);
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NUM_BLOCKS);

  // Block base address as shift-add: blk*36 = blk*32 + blk*4 (BLOCK_LEN = 36).
  function automatic logic [ADDR_W-1:0] blk_base(input logic [CNT_W-1:0] blk);
    logic [ADDR_W-1:0] b;
    b = ADDR_W'(blk);
    return (b << 5) + (b << 2);
  endfunction

  hog_state_e        state_q, state_d;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic              wr_q;
  logic [ADDR_W-1:0] wr_base_q, wr_base_d;
  logic              accept;
  logic              rd_en;
  logic              rd_fire;
  logic              rd_last;

  // Abort suppresses readiness so a block offered in the abort cycle is not consumed.
  assign oBlkReady = (state_q == ST_FILL) && !iAbort;
  assign accept    = oBlkReady && iBlkValid;
  assign rd_en     = (state_q == ST_READ) && !iAbort;

  assign oWR     = wr_q;
  assign oWrBase = wr_base_q;
  assign oBusy   = (state_q != ST_IDLE);
  assign oDONE   = (state_q == ST_DONE);
  assign oLast   = rd_last;

  hog_rd_stream #(
    .FEAT_LEN (FEAT_LEN),
    .ADDR_W   (ADDR_W)
  ) u_rd_stream (
    .clk_i   (iClk),
    .rst_ni  (iRst_n),
    .en_i    (rd_en),
    .ready_i (iRdReady),
    .addr_o  (oRdAddr),
    .valid_o (oRdValid),
    .last_o  (rd_last),
    .fire_o  (rd_fire)
  );

  // Next-state and block-counter logic; abort overrides every transition.
  always_comb begin
    state_d   = state_q;
    blk_cnt_d = blk_cnt_q;
    wr_base_d = accept ? blk_base(blk_cnt_q) : wr_base_q;
    if (iAbort) begin
      state_d   = ST_IDLE;
      blk_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            state_d   = ST_FILL;
            blk_cnt_d = '0;
          end
        end
        ST_FILL: begin
          if (accept) begin
            state_d   = ST_GAP;
            blk_cnt_d = blk_cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          state_d = (blk_cnt_q == LAST_BLK) ? ST_READ : ST_FILL;
        end
        ST_READ: begin
          if (rd_fire && rd_last) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d   = ST_IDLE;
          blk_cnt_d = '0;
        end
        default: begin
          state_d   = ST_IDLE;
          blk_cnt_d = '0;
        end
      endcase
    end
  end

  // State, block counter and the registered write strobe/base.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= ST_IDLE;
      blk_cnt_q <= '0;
      wr_q      <= 1'b0;
      wr_base_q <= '0;
    end else begin
      state_q   <= state_d;
      blk_cnt_q <= blk_cnt_d;
      wr_q      <= accept;
      wr_base_q <= wr_base_d;
    end
  end

endmodule

// File: tb/tb_hog_buffer_sequencer.sv
// Scoreboard bench for hog_buffer_sequencer: expected write bases and read
// addresses are queued when a frame is started and consumed as the DUT emits them.
module tb_hog_buffer_sequencer;
  import hog_pkg::*;

  localparam int FEAT = 3780;
  localparam int NB   = 105;
  localparam int BL   = 36;

  logic        iClk = 1'b0;
  logic        iRst_n, iStart, iAbort, iBlkValid, iRdReady;
  logic        oBlkReady, oWR, oRdValid, oLast, oBusy, oDONE;
  logic [11:0] oWrBase, oRdAddr;

  always #5 iClk = ~iClk;

  hog_buffer_sequencer dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iStart    (iStart),
    .iAbort    (iAbort),
    .iBlkValid (iBlkValid),
    .oBlkReady (oBlkReady),
    .oWR       (oWR),
    .oWrBase   (oWrBase),
    .oRdAddr   (oRdAddr),
    .oRdValid  (oRdValid),
    .iRdReady  (iRdReady),
    .oLast     (oLast),
    .oBusy     (oBusy),
    .oDONE     (oDONE)
  );

  int   n_chk = 0, n_fail = 0;
  int   cyc = 0;
  int   wr_exp[$];
  int   rd_exp[$];
  int   wr_seen = 0, hs_seen = 0, done_seen = 0;
  int   last_wr_cyc = 0, last_hs_cyc = 0;
  logic prev_wr = 1'b0, prev_rdv = 1'b0, prev_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Observe DUT outputs on the falling edge and settle against the scoreboard.
  task automatic sample();
    int tmp;
    cyc++;
    if (!iRst_n) begin
      prev_wr = 1'b0; prev_rdv = 1'b0; prev_done = 1'b0;
      return;
    end
    if (oWR) begin
      if (wr_exp.size() == 0) chk("wr_unexpected", oWR, 0);
      else chk("wr_base", oWrBase, wr_exp.pop_front());
      chk("wr_width", prev_wr, 0);
      if (wr_seen > 0) chk("wr_spacing", cyc - last_wr_cyc, 2);
      last_wr_cyc = cyc;
      wr_seen++;
    end
    if (oRdValid) begin
      chk("rd_blkready", oBlkReady, 0);
      if (!prev_rdv && hs_seen == 0) chk("rd_latency", cyc - last_wr_cyc, 2);
      if (rd_exp.size() == 0) chk("rd_unexpected", oRdValid, 0);
      else begin
        chk("rd_addr", oRdAddr, rd_exp[0]);
        chk("rd_last", oLast, (rd_exp[0] == FEAT - 1) ? 1 : 0);
        if (iRdReady) begin
          tmp = rd_exp.pop_front();
          hs_seen++;
          last_hs_cyc = cyc;
        end
      end
    end else if (oLast) begin
      chk("last_without_valid", oLast, 0);
    end
    if (oDONE) begin
      chk("done_latency", cyc - last_hs_cyc, 1);
      chk("done_width", prev_done, 0);
      chk("done_handshakes", hs_seen, FEAT);
      done_seen++;
    end
    prev_wr = oWR; prev_rdv = oRdValid; prev_done = oDONE;
  endtask

  task automatic tick();
    @(negedge iClk);
    sample();
    @(posedge iClk);
    #1;
  endtask

  task automatic flush();
    wr_exp.delete();
    rd_exp.delete();
  endtask

  task automatic start_frame();
    flush();
    for (int b = 0; b < NB; b++) wr_exp.push_back(b * BL);
    for (int a = 0; a < FEAT; a++) rd_exp.push_back(a);
    wr_seen = 0; hs_seen = 0; prev_rdv = 1'b0;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("busy_after_start", oBusy, 1);
  endtask

  task automatic fill(input int target);
    int n = 0;
    iBlkValid = 1'b1;
    while (wr_seen < target && n < 600) begin
      tick();
      n++;
    end
    chk("fill_count", wr_seen, target);
  endtask

  // mode 0: ready always high; mode 1: random ready plus a stray iStart pulse.
  task automatic read(input int mode, input int stop_hs);
    int  n = 0;
    int  d0 = done_seen;
    bit  poked = 0;
    while (n < 20000) begin
      if (stop_hs > 0 && hs_seen >= stop_hs) break;
      if (done_seen > d0) break;
      iRdReady = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 1 && !poked && hs_seen >= 500) begin
        iStart = 1'b1;
        poked = 1;
      end else begin
        iStart = 1'b0;
      end
      tick();
      n++;
    end
    iStart = 1'b0;
    iRdReady = 1'b0;
    if (stop_hs > 0) chk("read_reached_stop", hs_seen, stop_hs);
    else begin
      chk("done_count", done_seen, d0 + 1);
      chk("handshake_count", hs_seen, FEAT);
      chk("rd_queue_empty", rd_exp.size(), 0);
      chk("busy_after_done", oBusy, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_blkready"}, oBlkReady, 0);
    chk({tag, "_wr"}, oWR, 0);
    chk({tag, "_wrbase"}, oWrBase, 0);
    chk({tag, "_rdaddr"}, oRdAddr, 0);
    chk({tag, "_rdvalid"}, oRdValid, 0);
    chk({tag, "_last"}, oLast, 0);
    chk({tag, "_busy"}, oBusy, 0);
    chk({tag, "_done"}, oDONE, 0);
  endtask

  initial begin
    int d_before;
    iRst_n = 1'b0; iStart = 1'b0; iAbort = 1'b0; iBlkValid = 1'b0; iRdReady = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    check_all_zero("reset");
    iRst_n = 1'b1;
    tick();

    // Blocks offered and start+abort together in IDLE: nothing happens.
    iBlkValid = 1'b1; iRdReady = 1'b1;
    repeat (4) tick();
    chk("idle_no_wr", wr_seen, 0);
    chk("idle_busy", oBusy, 0);
    iStart = 1'b1; iAbort = 1'b1;
    tick();
    iStart = 1'b0; iAbort = 1'b0; iBlkValid = 1'b0; iRdReady = 1'b0;
    chk("start_abort_idle", oBusy, 0);

    // Frame 1: full fill, continuous ready.
    start_frame();
    fill(NB);
    iBlkValid = 1'b0;
    read(0, 0);

    // Frame 2: abort during FILL after 50 blocks.
    d_before = done_seen;
    start_frame();
    fill(50);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    chk("abort_fill_busy", oBusy, 0);
    chk("abort_fill_wr", oWR, 0);
    flush();
    repeat (4) tick();
    iBlkValid = 1'b0;
    chk("abort_fill_no_done", done_seen, d_before);
    chk("abort_fill_wr_total", wr_seen, 50);

    // Frame 3: restart from base 0, abort in READ at address 1000.
    start_frame();
    fill(NB);
    iBlkValid = 1'b0;
    read(0, 1000);
    chk("abort_rd_addr", oRdAddr, 1000);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    chk("abort_rd_busy", oBusy, 0);
    chk("abort_rd_valid", oRdValid, 0);
    flush();
    repeat (4) tick();
    chk("abort_rd_no_done", done_seen, d_before);

    // Frame 4: random ready, blocks offered and iStart pulsed during READ.
    start_frame();
    fill(NB);
    read(1, 0);
    iBlkValid = 1'b0;

    // Frame 5: asynchronous reset mid-READ.
    start_frame();
    fill(NB);
    iBlkValid = 1'b0;
    read(0, 300);
    iRdReady = 1'b1;
    #2;
    iRst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    iRdReady = 1'b0;
    flush();
    repeat (2) tick();
    iRst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", oBusy, 0);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("post_rst_start", oBusy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
